// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the banked FIFO controller and its memory controller.
// Bank select is address bit 0, so consecutive entries alternate banks.
package fifo_ctrl_pkg;
    localparam int DW         = 32;
    localparam int AW         = 3;
    localparam int DEPTH      = 1 << AW;
    localparam int OBUF_DEPTH = 2;
endpackage

// File: rtl/fifo_obuf.sv
// Two-entry in-order output buffer sitting behind the one-cycle memory read.
// Entry 0 is always the oldest; a pop shifts entry 1 down.
module fifo_obuf
    import fifo_ctrl_pkg::*;
#(
    parameter int DW = fifo_ctrl_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);
    logic [DW-1:0] ent_q [OBUF_DEPTH];
    logic [DW-1:0] ent_d [OBUF_DEPTH];
    logic [1:0]    occ_q, occ_d;
    logic [1:0]    slot;
    logic          pop;

    always_comb begin
        ent_d     = ent_q;
        out_valid = !rst && (occ_q != 2'd0);
        out_data  = ent_q[0];
        occ       = occ_q;
        pop       = out_valid && out_ready;
        // Slot for the incoming word is computed after the pop has shifted.
        slot      = occ_q - {1'b0, pop};
        if (pop) begin
            ent_d[0] = ent_q[1];
        end
        if (in_valid) begin
            ent_d[slot[0]] = in_data;
        end
        occ_d = rst ? 2'd0 : occ_q + {1'b0, in_valid} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        occ_q <= occ_d;
        ent_q <= ent_d;
    end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller over a two-bank external memory with one-cycle read latency.
// Same-bank write/read collisions are deferred by the memory; reads avoid that bank next cycle.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DW = fifo_ctrl_pkg::DW,
    parameter int AW = fifo_ctrl_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_wadr,
    output logic [DW-1:0] mem_di,
    output logic          mem_re,
    output logic [AW-1:0] mem_radr,
    input  logic [DW-1:0] mem_do_0,
    input  logic [DW-1:0] mem_do_1,
    output logic [AW:0]   level
);
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          pend_q, pend_d, pend_bank_q, pend_bank_d;
    logic          infl_q, infl_d, rbank_q, rbank_d;
    logic [AW:0]   fill;
    logic [1:0]    occ;
    logic [2:0]    budget, limit;
    logic          push_fire, pop_fire, blocked, issue, cap_valid;
    logic [DW-1:0] cap_data;

    always_comb begin
        fill       = wptr_q - rptr_q;
        // fill never exceeds 2**AW, so its MSB alone flags "full".
        push_ready = !rst && !fill[AW];
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;
        blocked    = pend_q && (rptr_q[0] == pend_bank_q);
        // occ + infl - pop_fire < 2, rearranged to stay unsigned.
        budget     = {1'b0, occ} + {2'b00, infl_q};
        limit      = 3'd2 + {2'b00, pop_fire};
        issue      = !rst && (fill != '0) && !blocked && (budget < limit);

        mem_we     = push_fire;
        mem_wadr   = rst ? '0 : wptr_q[AW-1:0];
        mem_di     = push_data;
        mem_re     = issue;
        mem_radr   = rst ? '0 : rptr_q[AW-1:0];
        level      = rst ? '0 : fill;

        wptr_d      = rst ? '0 : wptr_q + {{AW{1'b0}}, push_fire};
        rptr_d      = rst ? '0 : rptr_q + {{AW{1'b0}}, issue};
        pend_d      = !rst && mem_we && mem_re && (mem_wadr[0] == mem_radr[0]);
        pend_bank_d = mem_wadr[0];
        infl_d      = issue;
        rbank_d     = mem_radr[0];

        // Data returning for a read issued before reset is dropped here.
        cap_valid  = infl_q && !rst;
        cap_data   = rbank_q ? mem_do_1 : mem_do_0;
    end

    always_ff @(posedge clk) begin
        wptr_q      <= wptr_d;
        rptr_q      <= rptr_d;
        pend_q      <= pend_d;
        pend_bank_q <= pend_bank_d;
        infl_q      <= infl_d;
        rbank_q     <= rbank_d;
    end

    fifo_obuf #(.DW(DW)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cap_valid),
        .in_data   (cap_data),
        .out_valid (pop_valid),
        .out_ready (pop_ready),
        .out_data  (pop_data),
        .occ       (occ)
    );
endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomised scoreboard bench for fifo_ctrl with a behavioural two-bank memory
// that defers same-bank write/read collisions by one cycle.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_wadr;
    logic [DW-1:0] mem_di;
    logic          mem_re;
    logic [AW-1:0] mem_radr;
    logic [DW-1:0] mem_do_0 = '0;
    logic [DW-1:0] mem_do_1 = '0;
    logic [AW:0]   level;

    fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .mem_we     (mem_we),
        .mem_wadr   (mem_wadr),
        .mem_di     (mem_di),
        .mem_re     (mem_re),
        .mem_radr   (mem_radr),
        .mem_do_0   (mem_do_0),
        .mem_do_1   (mem_do_1),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural memory: colliding writes land one cycle late; the unread bank returns noise.
    logic [DW-1:0] mem [DEPTH];
    logic          dfr_valid = 1'b0;
    logic [AW-1:0] dfr_adr = '0;
    logic [DW-1:0] dfr_data = '0;

    always @(posedge clk) begin
        if (dfr_valid) mem[dfr_adr] <= dfr_data;
        dfr_valid <= 1'b0;
        if (mem_we) begin
            if (mem_re && (mem_wadr[0] == mem_radr[0])) begin
                dfr_valid <= 1'b1;
                dfr_adr   <= mem_wadr;
                dfr_data  <= mem_di;
            end else begin
                mem[mem_wadr] <= mem_di;
            end
        end
        if (mem_re) begin
            if (mem_radr[0]) begin
                mem_do_1 <= mem[mem_radr];
                mem_do_0 <= $urandom;
            end else begin
                mem_do_0 <= mem[mem_radr];
                mem_do_1 <= $urandom;
            end
        end
    end

    // Scoreboard: every accepted push queues its word as the next expected pop.
    logic [DW-1:0] exp_q [$];
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (push_valid && push_ready) exp_q.push_back(push_data);
    end

    // Reference counts: words written, read-issued, popped.
    int wcnt = 0, rcnt = 0, pcnt = 0, n_conflicts = 0;
    int m_lvl, m_out, m_occ;
    bit prev_re = 0, prev_conf = 0, prev_cbank = 0;
    bit m_pf, m_blk, m_re;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {push_ready, pop_valid, mem_we, mem_re, level, mem_wadr, mem_radr}, 0);
            wcnt = 0; rcnt = 0; pcnt = 0;
            prev_re = 0; prev_conf = 0;
        end else begin
            m_lvl = wcnt - rcnt;
            m_out = rcnt - pcnt;
            m_occ = m_out - int'(prev_re);
            m_pf  = pop_valid && pop_ready;
            chk("level", level, m_lvl);
            chk("push_ready", push_ready, m_lvl < DEPTH);
            chk("pop_valid", pop_valid, m_occ > 0);
            chk("occ_max", m_occ <= OBUF_DEPTH, 1);
            m_blk = prev_conf && ((rcnt % 2) == int'(prev_cbank));
            m_re  = (m_lvl > 0) && !m_blk && ((m_out - int'(m_pf)) < 2);
            chk("mem_re", mem_re, m_re);
            chk("mem_we", mem_we, push_valid && (m_lvl < DEPTH));
            if (mem_re) chk("mem_radr", mem_radr, rcnt % DEPTH);
            if (mem_we) begin
                chk("mem_wadr", mem_wadr, wcnt % DEPTH);
                chk("mem_di", mem_di, push_data);
            end
            if (m_pf) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_extra: got %0h, expected no pop (t=%0t)", pop_data, $time);
                end else begin
                    chk("pop_data", pop_data, exp_q.pop_front());
                end
            end
            prev_conf  = mem_we && mem_re && (mem_wadr[0] == mem_radr[0]);
            prev_cbank = mem_wadr[0];
            if (prev_conf) n_conflicts++;
            prev_re = mem_re;
            wcnt += int'(mem_we);
            rcnt += int'(mem_re);
            pcnt += int'(m_pf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_words(input int n, input int pv_pct, input int pr_pct,
                             input bit seq, input logic [DW-1:0] base, output int cyc);
        int sent;
        logic [DW-1:0] w;
        sent = 0;
        cyc = 0;
        w = seq ? base : $urandom;
        while (sent < n && cyc < 20 * n + 100) begin
            push_valid = ($urandom_range(99) < pv_pct);
            push_data  = w;
            pop_ready  = ($urandom_range(99) < pr_pct);
            @(negedge clk);
            if (push_valid && push_ready) begin
                sent++;
                w = seq ? w + 1 : $urandom;
            end
            tick();
            cyc++;
        end
        push_valid = 1'b0;
        chk("words_sent", sent, n);
    endtask

    task automatic drain(input int pr_pct);
        int cyc;
        cyc = 0;
        push_valid = 1'b0;
        while ((exp_q.size() != 0 || level != 0) && cyc < 1000) begin
            pop_ready = ($urandom_range(99) < pr_pct);
            tick();
            cyc++;
        end
        chk("drain_empty", exp_q.size(), 0);
        pop_ready = 1'b1;
        @(negedge clk);
        chk("drain_level", level, 0);
        chk("drain_pop_valid", pop_valid, 0);
        tick();
    endtask

    initial begin
        int cyc, acc, lat, conf0;
        logic [DW-1:0] w;

        do_reset(3);
        @(negedge clk);
        chk("ready_after_reset", push_ready, 1);
        tick();

        // First word: push edge t, read issue edge t+1, buffer capture edge t+2.
        pop_ready = 1'b1;
        push_valid = 1'b1;
        push_data = 32'hA5A5_0001;
        @(negedge clk);
        tick();
        push_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (pop_valid) break;
            lat++;
            tick();
        end
        chk("first_word_latency", lat, 3);
        tick();
        drain(100);

        // Fill with consumer stalled: 8 words in memory plus 2 already in the output buffer.
        do_reset(2);
        pop_ready = 1'b0;
        push_valid = 1'b1;
        w = 1;
        acc = 0;
        cyc = 0;
        while (cyc < 40) begin
            push_data = w;
            @(negedge clk);
            if (!push_ready) break;
            acc++;
            w++;
            tick();
            cyc++;
        end
        chk("fill_count", acc, DEPTH + 2);
        chk("fill_level", level, DEPTH);
        tick();
        @(negedge clk);
        chk("full_stays_blocked", push_ready, 0);
        tick();
        drain(100);

        // Collision: rptr=2, wptr=4 (both bank 0), then pop+push in the same cycle.
        do_reset(2);
        conf0 = n_conflicts;
        run_words(4, 100, 0, 1'b1, 32'h0000_0100, cyc);
        run_words(4, 100, 100, 1'b1, 32'h0000_0104, cyc);
        chk("conflict_seen", n_conflicts > conf0, 1);
        drain(100);

        // Streaming: one push per cycle, no stalls.
        do_reset(2);
        run_words(100, 100, 100, 1'b0, '0, cyc);
        chk("stream_cycles", cyc, 100);
        drain(100);

        // Backpressure with random producer and consumer.
        do_reset(2);
        run_words(200, 70, 50, 1'b0, '0, cyc);
        drain(60);

        // Reset with level=5 and a read in flight.
        do_reset(2);
        run_words(8, 100, 0, 1'b1, 32'h0000_0200, cyc);
        pop_ready = 1'b1;
        @(negedge clk);
        chk("pre_reset_issue", mem_re, 1);
        tick();
        chk("level_before_reset", level, 5);
        rst = 1'b1;
        pop_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_pop_valid", pop_valid, 0);
        chk("post_reset_level", level, 0);
        chk("post_reset_push_ready", push_ready, 1);
        tick();
        run_words(6, 100, 100, 1'b0, '0, cyc);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before time limit");
        $fatal(1, "watchdog");
    end
endmodule
